mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- DAT_W, 16, data and address width.
- LOCK_W, 10, lock address width (low bits of address).
REQ-002 Ports SHALL be (array index = core 0/1):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- read_request  in  [1:0]  per-core read request, level, held until ac.
- write_request  in  [1:0]  per-core write request, level, held until ac.
- read_adr  in  2x DAT_W  per-core read address.
- write_adr  in  2x DAT_W  per-core write address.
- write_dat  in  2x DAT_W  per-core write data.
- lock_adr  in  2x LOCK_W  per-core lock address.
- lock_en  in  [1:0]  lock acquire request, held until lock_ac.
- unlock_en  in  [1:0]  unlock, single-cycle pulse.
- mem_ac  out  [1:0]  access-complete pulse, one cycle.
- mem_dat  out  2x DAT_W  read data, valid while mem_ac[i].
- lock_ac  out  [1:0]  lock-granted pulse, one cycle.
- ram_adr  out  DAT_W  shared RAM address.
- ram_wdat  out  DAT_W  shared RAM write data.
- ram_we  out  1  shared RAM write enable.
- ram_rdat  in  DAT_W  shared RAM read data, one cycle after address.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-004 In IDLE, the arbiter SHALL pick one eligible requester per cycle using round-robin priority bit prio; prio SHALL flip to the other core after every grant.
REQ-005 When both request types are asserted by one core, the read SHALL be served first.
REQ-006 For a write grant:
- IDLE->ACCESS with ram_we=1, ram_adr=write_adr[i], ram_wdat=write_dat[i] for exactly one cycle.
- ACCESS->IDLE with mem_ac[i]=1 in the same cycle.
- Latency: 2 cycles from request seen in IDLE to ac.
REQ-007 For a read grant:
- ACCESS drives ram_adr=read_adr[i].
- RESP registers ram_rdat into mem_dat[i] and asserts mem_ac[i].
- RESP->IDLE.
- Latency: 3 cycles.
REQ-008 mem_dat[i] SHALL hold its last value until the next read ac to core i.
REQ-009 A request SHALL be eligible unless its address[LOCK_W-1:0] equals a held lock owned by the other core; blocked requests SHALL wait without ac.
REQ-010 Lock register: lock_valid, lock_owner, lock_reg.
REQ-011 lock_en[i] SHALL be granted (lock_ac[i] pulse next cycle, lock_valid=1, owner=i, lock_reg=lock_adr[i]) when:
- lock_valid=0, or
- the lock is already held by i on the same address.
REQ-012 Simultaneous lock_en from both cores with the lock free SHALL grant prio's core only; the other SHALL retry.
REQ-013 unlock_en[i] SHALL clear lock_valid only when owner=i; otherwise it SHALL be ignored.
REQ-014 An unlock SHALL make a blocked request eligible in the following cycle.
REQ-015 Lock arbitration SHALL run independently of, and concurrently with, the access FSM.
REQ-016 mem_ac and lock_ac SHALL never be asserted for a core that has deasserted its request.

Reset
REQ-017 While reset=0, the block SHALL force:
- state=IDLE, prio=0, lock_valid=0, lock_owner=0, lock_reg=0.
- mem_ac=0, lock_ac=0, ram_we=0, ram_adr=0, ram_wdat=0, mem_dat=0.
REQ-018 Reset asserted mid-access SHALL abort the access with no ac; any partially issued write is not retried.

Configuration
REQ-019 With MEM_ARB_LOCK_EN defined, locking SHALL behave per REQ-009 to REQ-014.
REQ-020 Without MEM_ARB_LOCK_EN:
- lock_ac[i] SHALL pulse one cycle after every lock_en[i].
- No lock state SHALL exist and no request SHALL ever be blocked.

Structure
REQ-021 A shared package mem_arb_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP) and constants NCORE=2 and LOCK_W=10.
REQ-022 Lock logic SHALL be one sub-module, mem_lock_table: inputs lock_en, unlock_en, lock_adr and prio; outputs lock_ac and a per-core blocked(adr) check.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Core0 write adr 0x0010 dat 0xBEEF, then core0 read 0x0010 -> write ac at cycle 2, read ac at cycle 3 with mem_dat[0]=0xBEEF.
- Both cores read at once from reset -> core0 ac first, core1 ac next; prio alternates on a repeat.
- Core0 lock 0x005, core1 write 0x0005 -> core1 stalls; core0 unlock -> core1 ac within 3 cycles, RAM holds core1's data.
- Both lock_en 0x007 from reset -> only lock_ac[0]; core1 lock_ac after core0 unlock.
- Reset pulsed during read RESP -> no mem_ac, all outputs zero, next request served normally.
- MEM_ARB_LOCK_EN undefined: core0 lock 0x005, core1 write 0x0005 -> both ac without stall.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the dual-core memory arbiter and its lock table.
package mem_arb_pkg;
  localparam int NCORE  = 2;
  localparam int LOCK_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_lock_table.sv
// Single-entry address lock shared by two cores; full locking only when MEM_ARB_LOCK_EN
// is defined, otherwise lock_en is simply acknowledged and nothing is ever blocked.
module mem_lock_table #(
  parameter int LOCK_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          lock_en,
  input  logic [1:0]          unlock_en,
  input  logic [2*LOCK_W-1:0] lock_adr,
  input  logic                prio,
  input  logic [2*LOCK_W-1:0] chk_rd_adr,
  input  logic [2*LOCK_W-1:0] chk_wr_adr,
  output logic [1:0]          lock_ac,
  output logic [1:0]          blk_rd,
  output logic [1:0]          blk_wr
);
  import mem_arb_pkg::*;

  logic [1:0] r_lock_ac;

  assign lock_ac = r_lock_ac;

`ifdef MEM_ARB_LOCK_EN
  logic              r_lock_valid;
  logic              r_lock_owner;
  logic [LOCK_W-1:0] r_lock_reg;
  logic [1:0]        w_can;
  logic [1:0]        w_gnt;

  // A core still seeing its own lock_ac pulse is masked so a held lock_en is not re-granted.
  always_comb begin
    w_can  = '0;
    blk_rd = '0;
    blk_wr = '0;
    for (int i = 0; i < NCORE; i++) begin
      w_can[i]  = lock_en[i] & ~r_lock_ac[i] &
                  (~r_lock_valid | ((r_lock_owner == 1'(i)) &&
                                    (r_lock_reg == lock_adr[i*LOCK_W +: LOCK_W])));
      blk_rd[i] = r_lock_valid && (r_lock_owner != 1'(i)) &&
                  (chk_rd_adr[i*LOCK_W +: LOCK_W] == r_lock_reg);
      blk_wr[i] = r_lock_valid && (r_lock_owner != 1'(i)) &&
                  (chk_wr_adr[i*LOCK_W +: LOCK_W] == r_lock_reg);
    end
    w_gnt = w_can;
    if (&w_can) w_gnt = prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock_ac    <= '0;
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
      r_lock_reg   <= '0;
    end else begin
      r_lock_ac <= w_gnt;
      if (r_lock_valid && unlock_en[r_lock_owner]) r_lock_valid <= 1'b0;
      if (|w_gnt) begin
        r_lock_valid <= 1'b1;
        r_lock_owner <= w_gnt[1];
        r_lock_reg   <= w_gnt[1] ? lock_adr[LOCK_W +: LOCK_W] : lock_adr[0 +: LOCK_W];
      end
    end
  end
`else
  logic w_unused;

  assign blk_rd   = '0;
  assign blk_wr   = '0;
  assign w_unused = ^{unlock_en, lock_adr, prio, chk_rd_adr, chk_wr_adr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lock_ac <= '0;
    else        r_lock_ac <= lock_en & ~r_lock_ac;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two cores access to one shared RAM, with an optional
// address lock (MEM_ARB_LOCK_EN) that stalls the other core's accesses to the locked address.
//   state  | meaning
//   IDLE   | pick an eligible requester, launch its RAM cycle
//   ACCESS | RAM address (and write strobe) on the bus; writes complete here
//   RESP   | read data returns from RAM and is captured for the core
module mem_arbiter #(
  parameter int DAT_W  = 16,
  parameter int LOCK_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          read_request,
  input  logic [1:0]          write_request,
  input  logic [2*DAT_W-1:0]  read_adr,
  input  logic [2*DAT_W-1:0]  write_adr,
  input  logic [2*DAT_W-1:0]  write_dat,
  input  logic [2*LOCK_W-1:0] lock_adr,
  input  logic [1:0]          lock_en,
  input  logic [1:0]          unlock_en,
  output logic [1:0]          mem_ac,
  output logic [2*DAT_W-1:0]  mem_dat,
  output logic [1:0]          lock_ac,
  output logic [DAT_W-1:0]    ram_adr,
  output logic [DAT_W-1:0]    ram_wdat,
  output logic                ram_we,
  input  logic [DAT_W-1:0]    ram_rdat
);
  import mem_arb_pkg::*;

  state_t              r_state, w_state_nxt;
  logic                r_prio, r_core, r_is_rd, r_ram_we;
  logic [1:0]          r_mem_ac;
  logic [2*DAT_W-1:0]  r_mem_dat;
  logic [DAT_W-1:0]    r_ram_adr, r_ram_wdat;
  logic [1:0]          w_blk_rd, w_blk_wr, w_rd_ok, w_wr_ok, w_any;
  logic                w_grant, w_gcore, w_grd, w_done, w_req_held;
  logic [2*LOCK_W-1:0] w_chk_rd, w_chk_wr;
  logic [DAT_W-1:0]    w_sel_rd_adr, w_sel_wr_adr, w_sel_wdat;

  always_comb begin
    w_chk_rd = '0;
    w_chk_wr = '0;
    for (int i = 0; i < NCORE; i++) begin
      w_chk_rd[i*LOCK_W +: LOCK_W] = read_adr[i*DAT_W +: LOCK_W];
      w_chk_wr[i*LOCK_W +: LOCK_W] = write_adr[i*DAT_W +: LOCK_W];
    end
  end

  mem_lock_table #(.LOCK_W(LOCK_W)) u_lock (
    .clk        (clk),
    .reset      (reset),
    .lock_en    (lock_en),
    .unlock_en  (unlock_en),
    .lock_adr   (lock_adr),
    .prio       (r_prio),
    .chk_rd_adr (w_chk_rd),
    .chk_wr_adr (w_chk_wr),
    .lock_ac    (lock_ac),
    .blk_rd     (w_blk_rd),
    .blk_wr     (w_blk_wr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A core whose ac pulse is still visible is skipped, since it drops its request only after seeing ac.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gcore     = r_prio;
    w_grd       = 1'b0;
    w_done      = 1'b0;
    w_rd_ok     = read_request  & ~w_blk_rd & ~r_mem_ac;
    w_wr_ok     = write_request & ~w_blk_wr & ~r_mem_ac;
    w_any       = w_rd_ok | w_wr_ok;
    case (r_state)
      IDLE: begin
        if (|w_any) begin
          w_grant     = 1'b1;
          w_gcore     = w_any[r_prio] ? r_prio : ~r_prio;
          w_grd       = w_rd_ok[w_gcore];
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_state_nxt = r_is_rd ? RESP : IDLE;
        w_done      = ~r_is_rd;
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sel_rd_adr = w_gcore ? read_adr[DAT_W +: DAT_W]  : read_adr[0 +: DAT_W];
  assign w_sel_wr_adr = w_gcore ? write_adr[DAT_W +: DAT_W] : write_adr[0 +: DAT_W];
  assign w_sel_wdat   = w_gcore ? write_dat[DAT_W +: DAT_W] : write_dat[0 +: DAT_W];
  assign w_req_held   = r_is_rd ? read_request[r_core] : write_request[r_core];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio     <= 1'b0;
      r_core     <= 1'b0;
      r_is_rd    <= 1'b0;
      r_mem_ac   <= '0;
      r_mem_dat  <= '0;
      r_ram_adr  <= '0;
      r_ram_wdat <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      r_mem_ac <= '0;
      r_ram_we <= 1'b0;
      if (w_grant) begin
        r_prio    <= ~w_gcore;
        r_core    <= w_gcore;
        r_is_rd   <= w_grd;
        r_ram_adr <= w_grd ? w_sel_rd_adr : w_sel_wr_adr;
        r_ram_we  <= ~w_grd;
        if (!w_grd) r_ram_wdat <= w_sel_wdat;
      end
      if (w_done && w_req_held) begin
        r_mem_ac[r_core] <= 1'b1;
        if (r_is_rd) begin
          if (r_core) r_mem_dat[DAT_W +: DAT_W] <= ram_rdat;
          else        r_mem_dat[0 +: DAT_W]     <= ram_rdat;
        end
      end
    end
  end

  assign mem_ac   = r_mem_ac;
  assign mem_dat  = r_mem_dat;
  assign ram_adr  = r_ram_adr;
  assign ram_wdat = r_ram_wdat;
  assign ram_we   = r_ram_we;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single accesses plus hand sequences
// for arbitration, locking (MEM_ARB_LOCK_EN) and reset abort.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  read_request = '0, write_request = '0, lock_en = '0, unlock_en = '0;
  logic [31:0] read_adr = '0, write_adr = '0, write_dat = '0;
  logic [19:0] lock_adr = '0;
  logic [1:0]  mem_ac, lock_ac;
  logic [31:0] mem_dat;
  logic [15:0] ram_adr, ram_wdat, ram_rdat;
  logic        ram_we;
  logic [15:0] ram [0:255];

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.DAT_W(16), .LOCK_W(10)) dut (
    .clk(clk), .reset(reset), .read_request(read_request), .write_request(write_request),
    .read_adr(read_adr), .write_adr(write_adr), .write_dat(write_dat), .lock_adr(lock_adr),
    .lock_en(lock_en), .unlock_en(unlock_en), .mem_ac(mem_ac), .mem_dat(mem_dat),
    .lock_ac(lock_ac), .ram_adr(ram_adr), .ram_wdat(ram_wdat), .ram_we(ram_we),
    .ram_rdat(ram_rdat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_adr[7:0]] <= ram_wdat;
    ram_rdat <= ram[ram_adr[7:0]];
  end

  typedef struct {
    int          core;
    bit          wr;
    logic [15:0] adr;
    logic [15:0] dat;
    int          lat;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    read_request = '0; write_request = '0; lock_en = '0; unlock_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_txn(input int core, input bit wr, input logic [15:0] adr,
                        input logic [15:0] dat, output int lat, output logic [15:0] rd,
                        output logic [1:0] acv);
    repeat (2) @(negedge clk);
    if (wr) begin
      write_adr[core*16 +: 16] = adr;
      write_dat[core*16 +: 16] = dat;
      write_request[core] = 1'b1;
    end else begin
      read_adr[core*16 +: 16] = adr;
      read_request[core] = 1'b1;
    end
    lat = 0; rd = '0; acv = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_ac[core]) begin
        lat = c; rd = mem_dat[core*16 +: 16]; acv = mem_ac;
        break;
      end
    end
    read_request[core] = 1'b0;
    write_request[core] = 1'b0;
  endtask

  task automatic both_read(output int t0, output int t1, output logic [15:0] d0,
                           output logic [15:0] d1);
    repeat (2) @(negedge clk);
    read_adr = {16'h0041, 16'h0040};
    read_request = 2'b11;
    t0 = 0; t1 = 0; d0 = '0; d1 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_ac[0] && read_request[0]) begin t0 = c; d0 = mem_dat[15:0];  read_request[0] = 1'b0; end
      if (mem_ac[1] && read_request[1]) begin t1 = c; d1 = mem_dat[31:16]; read_request[1] = 1'b0; end
      if (t0 != 0 && t1 != 0) break;
    end
    read_request = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, t0, t1, cnt;
    logic [15:0] rd, d0, d1;
    logic [1:0]  acv;
    bit          seen;

    vecs[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 2, 16'h0000};
    vecs[1] = '{0, 1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 16'h0020, 16'h1234, 2, 16'h0000};
    vecs[3] = '{1, 1'b0, 16'h0020, 16'h0000, 3, 16'h1234};
    vecs[4] = '{1, 1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF};
    vecs[5] = '{0, 1'b1, 16'h00FF, 16'h00C3, 2, 16'h0000};
    vecs[6] = '{0, 1'b0, 16'h00FF, 16'h0000, 3, 16'h00C3};
    vecs[7] = '{0, 1'b0, 16'h0020, 16'h0000, 3, 16'h1234};

    #2 reset = 1'b0;
    #20;
    check("rst_mem_ac", 32'(mem_ac), 32'h0);
    check("rst_lock_ac", 32'(lock_ac), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_adr", 32'(ram_adr), 32'h0);
    check("rst_ram_wdat", 32'(ram_wdat), 32'h0);
    check("rst_mem_dat", mem_dat, 32'h0);
    @(negedge clk) reset = 1'b1;

    do_txn(0, 1'b1, 16'h0040, 16'h1111, lat, rd, acv);
    check("pre_wr0_lat", 32'(lat), 32'd2);
    do_txn(1, 1'b1, 16'h0041, 16'h2222, lat, rd, acv);
    check("pre_wr1_lat", 32'(lat), 32'd2);

    do_reset();
    both_read(t0, t1, d0, d1);
    check("both1_t0", 32'(t0), 32'd3);
    check("both1_t1", 32'(t1), 32'd6);
    check("both1_d0", 32'(d0), 32'h1111);
    check("both1_d1", 32'(d1), 32'h2222);
    do_txn(0, 1'b0, 16'h0040, 16'h0000, lat, rd, acv);
    check("single_c0_lat", 32'(lat), 32'd3);
    both_read(t0, t1, d0, d1);
    check("both2_t1_first", 32'(t1), 32'd3);
    check("both2_t0_next", 32'(t0), 32'd6);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].core, vecs[i].wr, vecs[i].adr, vecs[i].dat, lat, rd, acv);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_acv", i), 32'(acv), 32'(2'b01 << vecs[i].core));
      if (vecs[i].wr) check($sformatf("vec%0d_ram", i), 32'(ram[vecs[i].adr[7:0]]), 32'(vecs[i].dat));
      else            check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
    end
    check("hold_dat0", 32'(mem_dat[15:0]), 32'h1234);
    check("hold_dat1", 32'(mem_dat[31:16]), 32'hBEEF);

    // Reset while the read is in RESP: nothing acknowledged, everything cleared.
    repeat (2) @(negedge clk);
    read_adr[15:0] = 16'h0010;
    read_request[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_mem_ac", 32'(mem_ac), 32'h0);
    check("abort_ram_adr", 32'(ram_adr), 32'h0);
    check("abort_ram_wdat", 32'(ram_wdat), 32'h0);
    check("abort_ram_we", 32'(ram_we), 32'h0);
    check("abort_mem_dat", mem_dat, 32'h0);
    check("abort_lock_ac", 32'(lock_ac), 32'h0);
    @(posedge clk); #1;
    check("abort_no_ac", 32'(mem_ac), 32'h0);
    @(negedge clk) reset = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_ac[0]) begin lat = c; rd = mem_dat[15:0]; break; end
    end
    read_request[0] = 1'b0;
    check("after_rst_lat", 32'(lat), 32'd3);
    check("after_rst_dat", 32'(rd), 32'hBEEF);

`ifdef MEM_ARB_LOCK_EN
    do_reset();
    @(negedge clk);
    lock_adr[9:0] = 10'h005;
    lock_en[0] = 1'b1;
    @(posedge clk); #1;
    check("lockA_ac", 32'(lock_ac), 32'h1);
    lock_en[0] = 1'b0;
    @(negedge clk);
    write_adr[31:16] = 16'h0005;
    write_dat[31:16] = 16'hC1C1;
    write_request[1] = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (mem_ac[1]) seen = 1'b1; end
    check("lockA_stall", 32'(seen), 32'h0);
    @(negedge clk) unlock_en[1] = 1'b1;
    @(posedge clk); #1 unlock_en[1] = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (mem_ac[1]) seen = 1'b1; end
    check("lockA_foreign_unlock_ignored", 32'(seen), 32'h0);
    @(negedge clk) unlock_en[0] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      unlock_en[0] = 1'b0;
      if (mem_ac[1]) begin lat = c; break; end
    end
    write_request[1] = 1'b0;
    check("lockA_release_lat_ok", 32'(lat >= 1 && lat <= 3), 32'h1);
    check("lockA_ram", 32'(ram[8'h05]), 32'hC1C1);

    do_reset();
    @(negedge clk);
    lock_adr = {10'h007, 10'h007};
    lock_en = 2'b11;
    @(posedge clk); #1;
    check("lockB_first", 32'(lock_ac), 32'h1);
    lock_en[0] = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (lock_ac[1]) seen = 1'b1; end
    check("lockB_c1_waits", 32'(seen), 32'h0);
    @(negedge clk) unlock_en[0] = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      unlock_en[0] = 1'b0;
      if (lock_ac[1]) begin cnt = c; break; end
    end
    lock_en[1] = 1'b0;
    check("lockB_c1_after_unlock", 32'(cnt), 32'd2);
`else
    do_reset();
    @(negedge clk);
    lock_adr[9:0] = 10'h005;
    lock_en[0] = 1'b1;
    @(posedge clk); #1;
    check("nolock_ac", 32'(lock_ac), 32'h1);
    lock_en[0] = 1'b0;
    @(posedge clk); #1;
    check("nolock_ac_pulse", 32'(lock_ac), 32'h0);
    do_txn(1, 1'b1, 16'h0005, 16'h5A5A, lat, rd, acv);
    check("nolock_wr_lat", 32'(lat), 32'd2);
    check("nolock_ram", 32'(ram[8'h05]), 32'h5A5A);
    do_txn(0, 1'b0, 16'h0005, 16'h0000, lat, rd, acv);
    check("nolock_rd_lat", 32'(lat), 32'd3);
    check("nolock_rd_dat", 32'(rd), 32'h5A5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
